// File: rtl/vram_pkg.sv
// Shared types and the logical-to-physical nametable mapping for nametable_vram.
package vram_pkg;

    typedef enum logic [1:0] {
        MIRROR_HORIZ     = 2'd0,
        MIRROR_VERT      = 2'd1,
        MIRROR_SINGLE_LO = 2'd2,
        MIRROR_SINGLE_HI = 2'd3
    } mirror_mode_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } vram_state_t;

    // Addresses travel at 32 bits so one function serves every PHYS_W; callers size-cast the result.
    function automatic logic [31:0] nt_map(input logic [31:0] addr, input mirror_mode_t mode,
                                           input int unsigned phys_w);
        logic        bank;
        logic [31:0] offset_mask;
        offset_mask = (32'd1 << (phys_w - 1)) - 32'd1;
        case (mode)
            MIRROR_HORIZ:     bank = addr[phys_w];
            MIRROR_VERT:      bank = addr[phys_w - 1];
            MIRROR_SINGLE_LO: bank = 1'b0;
            MIRROR_SINGLE_HI: bank = 1'b1;
            default:          bank = 1'b0;
        endcase
        return ({31'd0, bank} << (phys_w - 1)) | (addr & offset_mask);
    endfunction

endpackage

// File: rtl/dp_ram_core.sv
// True dual-port, read-first, registered-output RAM; contents are cleared by the owner, not by reset.
module dp_ram_core #(
    parameter int DATA_W = 8,
    parameter int PHYS_W = 11
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we_a,
    input  logic [PHYS_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    input  logic              we_b,
    input  logic [PHYS_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b
);

`ifdef SYNTH
    altsyncram #(
        .operation_mode                     ("BIDIR_DUAL_PORT"),
        .width_a                            (DATA_W),
        .widthad_a                          (PHYS_W),
        .numwords_a                         (2 ** PHYS_W),
        .width_b                            (DATA_W),
        .widthad_b                          (PHYS_W),
        .numwords_b                         (2 ** PHYS_W),
        .outdata_reg_a                      ("UNREGISTERED"),
        .outdata_reg_b                      ("UNREGISTERED"),
        .address_reg_b                      ("CLOCK0"),
        .indata_reg_b                       ("CLOCK0"),
        .wrcontrol_wraddress_reg_b          ("CLOCK0"),
        .read_during_write_mode_port_a      ("OLD_DATA"),
        .read_during_write_mode_port_b      ("OLD_DATA"),
        .read_during_write_mode_mixed_ports ("OLD_DATA")
    ) u_ram (
        .clock0    (clk),
        .clocken0  (en),
        .wren_a    (we_a),
        .address_a (addr_a),
        .data_a    (din_a),
        .q_a       (dout_a),
        .wren_b    (we_b),
        .address_b (addr_b),
        .data_b    (din_b),
        .q_b       (dout_b)
    );
`else
    logic [DATA_W-1:0] mem [2 ** PHYS_W];

    // NOTE: the array has no reset branch; a reset on storage would stop it mapping to block RAM.
    // NOTE: non-blocking reads sample the pre-edge contents, which is what makes every port read-first.
    always_ff @(posedge clk) begin
        if (en) begin
            dout_a <= mem[addr_a];
            dout_b <= mem[addr_b];
            if (we_b) mem[addr_b] <= din_b;
            if (we_a) mem[addr_a] <= din_a;
        end
    end
`endif

endmodule

// File: rtl/nametable_vram.sv
// Nametable RAM: mirroring-mode address mapping, post-reset zero sweep and gated registered read ports.
module nametable_vram
    import vram_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int PHYS_W = 11,
    localparam int ADDR_W = PHYS_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic [1:0]        mirror_mode,
    input  logic              clear_req,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic              re_a,
    input  logic              re_b,
    input  logic [DATA_W-1:0] din_a,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_a,
    output logic [DATA_W-1:0] dout_b,
    output logic              valid_a,
    output logic              valid_b,
    output logic              busy
);

    localparam logic [PHYS_W-1:0] CLR_LAST = '1;

    vram_state_t       state, state_nxt;
    logic [PHYS_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              ready;
    logic [PHYS_W-1:0] phys_a, phys_b;
    logic              ram_we_a, ram_we_b;
    logic [PHYS_W-1:0] ram_addr_a;
    logic [DATA_W-1:0] ram_din_a;
    logic [DATA_W-1:0] ram_dout_a, ram_dout_b;

    assign ready  = (state == READY);
    assign busy   = ~ready;
    assign phys_a = PHYS_W'(nt_map(32'(addr_a), mirror_mode_t'(mirror_mode), PHYS_W));
    assign phys_b = PHYS_W'(nt_map(32'(addr_b), mirror_mode_t'(mirror_mode), PHYS_W));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            CLEAR: begin
                if (clear_req) begin
                    clr_cnt_nxt = '0;
                end else if (clr_cnt == CLR_LAST) begin
                    state_nxt   = READY;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            READY: begin
                if (clear_req) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // Port A is borrowed by the sweep; B's write is dropped on an address clash so A wins.
    always_comb begin
        ram_we_a   = ready & we_a;
        ram_addr_a = phys_a;
        ram_din_a  = din_a;
        ram_we_b   = ready & we_b & ~(we_a && (phys_a == phys_b));
        if (!ready) begin
            ram_we_a   = 1'b1;
            ram_addr_a = clr_cnt;
            ram_din_a  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            valid_a <= 1'b0;
            valid_b <= 1'b0;
        end else if (clk_en) begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            valid_a <= re_a & ready;
            valid_b <= re_b & ready;
        end
    end

    dp_ram_core #(
        .DATA_W (DATA_W),
        .PHYS_W (PHYS_W)
    ) u_core (
        .clk    (clk),
        .en     (clk_en),
        .we_a   (ram_we_a),
        .addr_a (ram_addr_a),
        .din_a  (ram_din_a),
        .dout_a (ram_dout_a),
        .we_b   (ram_we_b),
        .addr_b (phys_b),
        .din_b  (din_b),
        .dout_b (ram_dout_b)
    );

    // Gating on the async-reset valid flops gives zero data during the sweep and right at reset.
    assign dout_a = valid_a ? ram_dout_a : '0;
    assign dout_b = valid_b ? ram_dout_b : '0;

endmodule

// File: tb/tb_nametable_vram.sv
// Self-checking bench for nametable_vram: reference model feeds a scoreboard popped after each tick.
module tb_nametable_vram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic [1:0]  mirror_mode;
    logic        clear_req;
    logic [11:0] addr_a, addr_b;
    logic        we_a, we_b, re_a, re_b;
    logic [7:0]  din_a, din_b;
    logic [7:0]  dout_a, dout_b;
    logic        valid_a, valid_b;
    logic        busy;

    nametable_vram #(.DATA_W(8), .PHYS_W(11)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .mirror_mode (mirror_mode),
        .clear_req   (clear_req),
        .addr_a      (addr_a),
        .addr_b      (addr_b),
        .we_a        (we_a),
        .we_b        (we_b),
        .re_a        (re_a),
        .re_b        (re_b),
        .din_a       (din_a),
        .din_b       (din_b),
        .dout_a      (dout_a),
        .dout_b      (dout_b),
        .valid_a     (valid_a),
        .valid_b     (valid_b),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       port;
        logic [7:0] data;
        logic       valid;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] m_mem [2048];
    logic       m_busy = 1'b1;
    int         m_cnt  = 0;
    logic [7:0] last_a_d = 8'h00, last_b_d = 8'h00;
    logic       last_a_v = 1'b0, last_b_v = 1'b0;
    logic [1:0] mode_v = 2'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int tb_map(input logic [11:0] a, input logic [1:0] m);
        case (m)
            2'd0:    return int'({a[11], a[9:0]});
            2'd1:    return int'({a[10], a[9:0]});
            2'd2:    return int'({1'b0, a[9:0]});
            default: return int'({1'b1, a[9:0]});
        endcase
    endfunction

    task automatic cycle(input string tag, input logic [1:0] m,
                         input logic wa, input logic ra, input logic [11:0] aa, input logic [7:0] da,
                         input logic wb, input logic rb, input logic [11:0] ab, input logic [7:0] db,
                         input logic clr);
        exp_t ea, eb;
        int   pa, pb;
        mirror_mode = m;  clear_req = clr;
        we_a = wa; re_a = ra; addr_a = aa; din_a = da;
        we_b = wb; re_b = rb; addr_b = ab; din_b = db;
        ea.tag = {tag, "_a"}; ea.port = 1'b0;
        eb.tag = {tag, "_b"}; eb.port = 1'b1;
        if (!clk_en) begin
            ea.data = last_a_d; ea.valid = last_a_v;
            eb.data = last_b_d; eb.valid = last_b_v;
        end else if (m_busy) begin
            ea.data = 8'h00; ea.valid = 1'b0;
            eb.data = 8'h00; eb.valid = 1'b0;
            m_mem[m_cnt] = 8'h00;
            if (clr)                m_cnt = 0;
            else if (m_cnt == 2047) begin m_busy = 1'b0; m_cnt = 0; end
            else                    m_cnt++;
        end else begin
            pa = tb_map(aa, m);
            pb = tb_map(ab, m);
            ea.valid = ra; ea.data = ra ? m_mem[pa] : 8'h00;
            eb.valid = rb; eb.data = rb ? m_mem[pb] : 8'h00;
            if (wb) m_mem[pb] = db;
            if (wa) m_mem[pa] = da;
            if (clr) begin m_busy = 1'b1; m_cnt = 0; end
        end
        last_a_d = ea.data; last_a_v = ea.valid;
        last_b_d = eb.data; last_b_v = eb.valid;
        sb.push_back(ea);
        sb.push_back(eb);
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.port) begin
                check({e.tag, "_dout"},  32'(dout_b),  32'(e.data));
                check({e.tag, "_valid"}, 32'(valid_b), 32'(e.valid));
            end else begin
                check({e.tag, "_dout"},  32'(dout_a),  32'(e.data));
                check({e.tag, "_valid"}, 32'(valid_a), 32'(e.valid));
            end
        end
        check({tag, "_busy"}, 32'(busy), 32'(m_busy));
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, mode_v, 1'b0, 1'b1, 12'h000, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dout_a"},  32'(dout_a),  32'h0);
        check({tag, "_dout_b"},  32'(dout_b),  32'h0);
        check({tag, "_valid_a"}, 32'(valid_a), 32'h0);
        check({tag, "_valid_b"}, 32'(valid_b), 32'h0);
        check({tag, "_busy"},    32'(busy),    32'h1);
    endtask

    task automatic apply_reset(input string tag);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values(tag);
        m_busy = 1'b1; m_cnt = 0;
        last_a_d = 8'h00; last_a_v = 1'b0;
        last_b_d = 8'h00; last_b_v = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; mirror_mode = 2'd0; clear_req = 1'b0;
        addr_a = '0; addr_b = '0; we_a = 1'b0; we_b = 1'b0; re_a = 1'b0; re_b = 1'b0;
        din_a = '0; din_b = '0;
        for (int i = 0; i < 2048; i++) m_mem[i] = 8'hxx;
        #11;
        check_reset_values("por");
        #1;
        rst_n = 1'b1;

        // Power-on sweep with a read held on port A throughout.
        for (int i = 0; i < 2048; i++)
            cycle("sweep", 2'd0, 1'b0, 1'b1, 12'h000, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
        cycle("first_rd", 2'd0, 1'b0, 1'b1, 12'h000, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);

        // Vertical mirroring.
        mode_v = 2'd1;
        cycle("v_wr",    2'd1, 1'b1, 1'b0, 12'h005, 8'hA5, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
        cycle("v_rd805", 2'd1, 1'b0, 1'b1, 12'h805, 8'h00, 1'b0, 1'b1, 12'h405, 8'h00, 1'b0);
        clk_en = 1'b0;
        cycle("hold",    2'd1, 1'b1, 1'b1, 12'h005, 8'h00, 1'b1, 1'b0, 12'h405, 8'h99, 1'b0);
        clk_en = 1'b1;
        cycle("v_rd405", 2'd1, 1'b0, 1'b1, 12'h405, 8'h00, 1'b0, 1'b1, 12'h005, 8'h00, 1'b0);

        // Horizontal mirroring, then switch mode on the next tick.
        mode_v = 2'd0;
        cycle("h_wr",    2'd0, 1'b1, 1'b0, 12'h010, 8'h3C, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
        cycle("h_rd410", 2'd0, 1'b0, 1'b1, 12'h410, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
        cycle("v_rd410", 2'd1, 1'b0, 1'b1, 12'h410, 8'h00, 1'b0, 1'b1, 12'hC10, 8'h00, 1'b0);
        cycle("s_hi",    2'd3, 1'b0, 1'b1, 12'h010, 8'h00, 1'b0, 1'b1, 12'h810, 8'h00, 1'b0);

        // Both ports write physical 0x123; A must win.
        cycle("coll_wr", 2'd0, 1'b1, 1'b0, 12'h123, 8'h11, 1'b1, 1'b0, 12'h523, 8'h22, 1'b0);
        cycle("coll_rd", 2'd0, 1'b0, 1'b1, 12'h123, 8'h00, 1'b0, 1'b1, 12'h923, 8'h00, 1'b0);

        // Cross-port and same-port read-during-write return old data.
        cycle("rdw_x",   2'd0, 1'b1, 1'b0, 12'h040, 8'h77, 1'b0, 1'b1, 12'h040, 8'h00, 1'b0);
        cycle("rdw_nxt", 2'd0, 1'b0, 1'b1, 12'h040, 8'h00, 1'b0, 1'b1, 12'h040, 8'h00, 1'b0);
        cycle("rdw_s",   2'd0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b1, 12'h040, 8'h88, 1'b0);
        cycle("rdw_s2",  2'd0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 12'h040, 8'h00, 1'b0);

        // Fill everything with 0xFF via both ports.
        for (int i = 0; i < 1024; i++)
            cycle("fill", 2'd0, 1'b1, 1'b0, 12'(i), 8'hFF, 1'b1, 1'b0, 12'(i) | 12'h800, 8'hFF, 1'b0);
        cycle("fill_rd", 2'd0, 1'b0, 1'b1, 12'h3FF, 8'h00, 1'b0, 1'b1, 12'hBFF, 8'h00, 1'b0);

        // Clear pulse, reset at tick 100 of the sweep, then a full sweep with a mid-sweep restart.
        cycle("clr_req", 2'd0, 1'b0, 1'b1, 12'h001, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1);
        idle("clr_run", 99);
        apply_reset("rst_sweep");
        idle("resweep", 50);
        cycle("restart", 2'd0, 1'b0, 1'b1, 12'h000, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1);
        for (int i = 0; i < 4096 && m_busy; i++) idle("resweep2", 1);

        for (int i = 0; i < 1024; i++)
            cycle("zero", 2'd0, 1'b0, 1'b1, 12'(i), 8'h00, 1'b0, 1'b1, 12'(i) | 12'h800, 8'h00, 1'b0);

        // Reset while a valid read is being presented.
        cycle("pre_wr", 2'd2, 1'b1, 1'b0, 12'h321, 8'h5A, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
        cycle("pre_rd", 2'd2, 1'b0, 1'b1, 12'hB21, 8'h00, 1'b0, 1'b1, 12'h321, 8'h00, 1'b0);
        apply_reset("rst_read");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
